mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_divider.sv | 70 +++++++
 rtl/mul_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, latencies.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Cycles from the accept edge to the cycle in which done is high.
    localparam int MUL_DONE_LATENCY = 2;

    function automatic int div_done_latency(input int width);
        return width + 2;
    endfunction

    // op[0] clear selects the two's-complement flavour of either operation.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    // op[1] set selects division.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Latency: DATA_WIDTH cycles after start; done is high during the final iteration.
// Backpressure: none; start is assumed only while idle and restarts the divider.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dsr_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          fits;

    // Trial subtraction of the divisor from the partial remainder with the next dividend bit.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dsr_q};
        fits    = ~diff[W];
    end

    // Load operands on start, then retire one quotient bit per cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dsr_q  <= divisor;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= fits ? diff[W-1:0] : shifted[W-1:0];
            quo_q  <= {quo_q[W-2:0], fits};
            cnt_q  <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Final iteration in progress: results settle at the end of this cycle.
    assign done      = busy_q && (cnt_q == CW'(W - 1));
    assign busy      = busy_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Signed/unsigned multiply and divide unit with HI/LO results; divider present only with MDU_DIV_EN.
// Latency: done 2 cycles after accept for multiply, DATA_WIDTH+2 for divide (2 without MDU_DIV_EN).
// Backpressure: start is accepted only in IDLE; starts while busy are dropped, not queued.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] HI_res,
    output logic [DATA_WIDTH-1:0] LO_res,
    output logic                  div_by_zero
);

    localparam int W = DATA_WIDTH;

    state_e         state_q;
    state_e         state_d;

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [1:0]     op_q;
    logic           accept;

    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;
    logic [2*W-1:0] product;

    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           dbz_q;
    logic [W-1:0]   hi_d;
    logic [W-1:0]   lo_d;
    logic           dbz_d;
    logic           load_res;

    assign accept = start && (state_q == IDLE);

`ifdef MDU_DIV_EN
    logic         div_start;
    logic         div_busy;
    logic         div_done;
    logic [W-1:0] div_quo;
    logic [W-1:0] div_rem;
    logic         a_in_neg;
    logic         b_in_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;

    // Divider works on magnitudes taken from the live inputs at the accept edge.
    always_comb begin
        a_in_neg  = is_signed_op(op) && A[W-1];
        b_in_neg  = is_signed_op(op) && B[W-1];
        a_mag     = a_in_neg ? -A : A;
        b_mag     = b_in_neg ? -B : B;
        div_start = accept && is_div_op(op);
    end

    mdu_divider #(
        .DATA_WIDTH (W)
    ) u_divider (
        .CLK       (CLK),
        .RST       (RST),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`endif

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: every operation ends in a single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MDU_DIV_EN
                    state_d = is_div_op(op) ? DIV : MUL;
`else
                    state_d = MUL;
`endif
                end
            end
            MUL:  state_d = DONE;
`ifdef MDU_DIV_EN
            DIV: begin
                if (div_done) begin
                    state_d = FIX;
                end else if (!div_busy) begin
                    // Divider dropped out unexpectedly; abandon rather than hang.
                    state_d = IDLE;
                end
            end
            FIX:  state_d = DONE;
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture at accept so later input changes cannot disturb the operation.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= 2'b00;
        end else if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op;
        end
    end

    // Full-width product of the operands, sign- or zero-extended by op.
    always_comb begin
        ext_a   = is_signed_op(op_q) ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
        ext_b   = is_signed_op(op_q) ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
        product = ext_a * ext_b;
    end

    // Result selection for the transition into DONE; divides without a divider hold HI/LO.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        dbz_d = 1'b0;
        case (state_q)
            MUL: begin
                if (!is_div_op(op_q)) begin
                    hi_d = product[2*W-1:W];
                    lo_d = product[W-1:0];
                end
            end
`ifdef MDU_DIV_EN
            FIX: begin
                if (b_q == '0) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (is_signed_op(op_q)) begin
                    // Quotient truncates toward zero; remainder follows the dividend's sign.
                    // MIN / -1 lands on MIN naturally since -MIN == MIN in W bits.
                    lo_d = (a_q[W-1] ^ b_q[W-1]) ? -div_quo : div_quo;
                    hi_d = a_q[W-1] ? -div_rem : div_rem;
                end else begin
                    lo_d = div_quo;
                    hi_d = div_rem;
                end
            end
`endif
            default: begin
                hi_d  = hi_q;
                lo_d  = lo_q;
                dbz_d = 1'b0;
            end
        endcase
    end

    assign load_res = (state_d == DONE) && (state_q != DONE);

    // HI/LO registers change only on entry to DONE and hold until the next completion.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else if (load_res) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dbz_q <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign HI_res      = hi_q;
    assign LO_res      = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: arithmetic model compared every cycle plus directed literal vectors.
// Latency: checks done timing of 2 (multiply) and 34 or 2 (divide, by MDU_DIV_EN).
// Backpressure: exercises starts dropped while busy and reset abort mid-operation.
module tb_mul_div_unit;

`ifdef MDU_DIV_EN
    localparam int DIVLAT = 34;
    localparam int STRAY  = 5;
    localparam int RSTCYC = 10;
`else
    localparam int DIVLAT = 2;
    localparam int STRAY  = 1;
    localparam int RSTCYC = 1;
`endif

    logic        CLK;
    logic        RST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI_res;
    logic [31:0] LO_res;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .HI_res      (HI_res),
        .LO_res      (LO_res),
        .div_by_zero (div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: returns {div_by_zero, HI, LO}.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] phi,
                                          input logic [31:0] plo);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        logic [63:0]     r;
        r = 64'd0;
        if (o == 2'b00) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            r  = sp;
            return {1'b0, r};
        end
        if (o == 2'b01) begin
            up = {32'd0, a} * {32'd0, b};
            r  = up;
            return {1'b0, r};
        end
`ifdef MDU_DIV_EN
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        if (o == 2'b10) begin
            sa = a;
            sb = b;
            if (a == 32'h80000000 && sb == -1) return {1'b0, 32'd0, 32'h80000000};
            return {1'b0, 32'(sa % sb), 32'(sa / sb)};
        end
        return {1'b0, a % b, a / b};
`else
        sa = 0;
        sb = 0;
        return {1'b0, phi, plo};
`endif
    endfunction

    logic        m_busy;
    logic        m_done;
    logic        m_dbz;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [1:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          m_cyc;
    int          m_lat;

    // Model: done is high in cycle m_lat counted from the accept edge; results appear with it.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dbz  = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else if (m_busy) begin
            if (m_cyc == m_lat) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end else begin
                m_cyc++;
                if (m_cyc == m_lat) begin
                    m_done = 1'b1;
                    {m_dbz, m_hi, m_lo} = model(m_op, m_a, m_b, m_hi, m_lo);
                end
            end
        end else if (start) begin
            m_busy = 1'b1;
            m_op   = op;
            m_a    = A;
            m_b    = B;
            m_lat  = op[1] ? DIVLAT : 2;
            m_cyc  = 1;
        end
    end

    // Compare every cycle against the model.
    always @(negedge CLK) begin
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        check("hi", 64'(HI_res), 64'(m_hi));
        check("lo", 64'(LO_res), 64'(m_lo));
        if (m_done || !RST) check("dbz", 64'(div_by_zero), 64'(m_dbz));
    end

    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge CLK); #2;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge CLK); #2;
        start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(output int k);
        k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz);
        int k;
        logic [31:0] xh;
        logic [31:0] xl;
        logic        xd;
        xh = ehi; xl = elo; xd = edbz;
`ifndef MDU_DIV_EN
        if (o[1]) begin
            xh = prev_hi; xl = prev_lo; xd = 1'b0;
        end
`endif
        issue(o, a, b);
        wait_done(k);
        check({name, " latency"}, 64'(k), 64'(o[1] ? DIVLAT : 2));
        check({name, " HI"}, 64'(HI_res), 64'(xh));
        check({name, " LO"}, 64'(LO_res), 64'(xl));
        check({name, " dbz"}, 64'(div_by_zero), 64'(xd));
        prev_hi = xh;
        prev_lo = xl;
    endtask

    initial begin
        int k;
        int dn;
        RST = 1'b0; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset HI", 64'(HI_res), 64'd0);
        check("reset LO", 64'(LO_res), 64'd0);
        @(posedge CLK); #2;
        RST = 1'b1;

        run_op("multu max*2", 2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        run_op("mult -3*5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("mult min*min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
        run_op("mult 7*-1", 2'b00, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0);
        run_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_op("divu 9/0", 2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1);
        run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div -9/0", 2'b10, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1);
        run_op("divu max/1", 2'b11, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0);
        run_op("multu after div", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        // A second start while busy must be dropped: exactly one done follows.
        issue(2'b10, 32'd100, 32'd7);
        repeat (STRAY - 1) begin
            @(posedge CLK); #2;
        end
        start = 1'b1; op = 2'b01; A = 32'd3; B = 32'd3;
        @(posedge CLK); #2;
        start = 1'b0;
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (done) dn++;
        end
        check("stray start done count", 64'(dn), 64'd1);
`ifdef MDU_DIV_EN
        check("stray start HI", 64'(HI_res), 64'd2);
        check("stray start LO", 64'(LO_res), 64'd14);
`else
        check("stray start HI", 64'(HI_res), 64'(prev_hi));
        check("stray start LO", 64'(LO_res), 64'(prev_lo));
`endif

        // Reset in the middle of an operation clears everything at once.
        issue(2'b11, 32'd100, 32'd7);
        repeat (RSTCYC - 1) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort HI", 64'(HI_res), 64'd0);
        check("abort LO", 64'(LO_res), 64'd0);
        check("abort dbz", 64'(div_by_zero), 64'd0);
        @(posedge CLK);
        @(posedge CLK); #2;
        RST = 1'b1;
        start = 1'b1; op = 2'b01; A = 32'd6; B = 32'd7;
        @(posedge CLK); #2;
        start = 1'b0;
        wait_done(k);
        check("first start after reset latency", 64'(k), 64'd2);
        check("first start after reset LO", 64'(LO_res), 64'd42);
        check("first start after reset HI", 64'(HI_res), 64'd0);
        repeat (3) @(posedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
